mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max wait cycles for mem_ack before a bus error (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc  input  32  fetch address from cpu.
REQ-005 load  input  1  cpu data read request, valid in DECODE.
REQ-006 store  input  1  cpu data write request, valid in DECODE.
REQ-007 address  input  32  cpu data address.
REQ-008 store_data  input  32  cpu write data.
REQ-009 inst  output  32  registered instruction to cpu.
REQ-010 load_data  output  32  registered read data to cpu.
REQ-011 cpu_en  output  1  one-cycle cpu step enable; cpu commits pc/regfile only when high.
REQ-012 mem_req  output  1  memory request.
REQ-013 mem_we  output  1  write enable, 1 = write.
REQ-014 mem_addr  output  32  memory address.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-017 mem_ack  input  1  one-cycle transfer completion.
REQ-018 bus_err  output  1  sticky timeout flag.

Function
REQ-019 States SHALL be FETCH, DECODE, DATA, COMMIT, HALT.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack SHALL capture mem_rdata into inst and go to DECODE.
REQ-021 DECODE: mem_req=0; if load or store, go to DATA; otherwise assert cpu_en this cycle and go to FETCH.
REQ-022 DATA: mem_req=1, mem_addr=address, mem_we=store, mem_wdata=store_data; on mem_ack, if load, SHALL capture mem_rdata into load_data; go to COMMIT.
REQ-023 COMMIT: cpu_en=1 for exactly one cycle; go to FETCH.
REQ-024 If load and store are both high in DECODE, store SHALL win (mem_we=1), and load_data SHALL be unchanged.
REQ-025 While mem_req is high, mem_addr, mem_we and mem_wdata SHALL be held stable until the mem_ack cycle.
REQ-026 mem_ack outside FETCH/DATA SHALL be ignored.
REQ-027 mem_wdata SHALL be 0 whenever mem_we=0.
REQ-028 Minimum latency: non-memory instruction = 2 cycles (FETCH with same-cycle ack, DECODE); memory instruction = 4 cycles.
REQ-029 cpu_en SHALL be high in at most one cycle per fetched instruction.

Reset
REQ-030 While reset is high: state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_en=0, inst=32'h00000013 (NOP), load_data=0, bus_err=0.
REQ-031 The first cycle after reset deasserts SHALL assert mem_req with mem_addr=pc.
REQ-032 Reset asserted mid-transaction SHALL abandon it immediately; a late mem_ack after reset SHALL be ignored unless in FETCH with mem_req high.

Configuration
REQ-033 Macro MEM_ARB_TIMEOUT_EN defined: a wait counter SHALL clear on entry to FETCH/DATA and count each cycle with mem_req=1 and mem_ack=0.
REQ-034 When the counter reaches TIMEOUT_CYCLES, the arbiter SHALL drop mem_req, set bus_err, and enter HALT; HALT SHALL be left only by reset, with cpu_en=0.
REQ-035 Macro not defined: no counter; bus_err SHALL be constant 0; wait for mem_ack is unbounded; HALT SHALL be unreachable.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum, NOP constant 32'h00000013, and default TIMEOUT_CYCLES.
REQ-037 Sub-module mem_arb_timeout (counter + compare) SHALL be instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-038 After reset, pc=0x0, ack same cycle with rdata=0x00500093 (non-memory), load=store=0 -> inst=0x00500093, cpu_en high in the 2nd cycle only.
REQ-039 Load: fetch ack, then DECODE with load=1 and address=0x100, ack with rdata=0xDEADBEEF -> mem_we=0, mem_addr=0x100, load_data=0xDEADBEEF, cpu_en high in COMMIT.
REQ-040 Store with ack delayed 3 cycles, address=0x200, store_data=0x12345678 -> req/addr/we/wdata stable for 4 cycles, then cpu_en one cycle.
REQ-041 Spurious mem_ack in DECODE/COMMIT -> no state change and no capture.
REQ-042 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> mem_req drops after 4 cycles, bus_err=1 and held; reset clears bus_err and fetching resumes.
REQ-043 Reset pulse in DATA with ack pending -> outputs at reset values, next fetch from current pc, and no cpu_en for the aborted instruction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } arb_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/mem_arb_timeout.sv
// Bus-wait watchdog: down-counter reloaded while no request is outstanding,
// flags expiry on the last tolerated wait cycle without an ack.
import mem_arb_pkg::*;

module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = req & ~ack;
  assign expired = waiting & (cnt_q == '0);

  // Every entry to FETCH/DATA comes from a non-request state, so reloading
  // whenever req is low restarts the count on each new transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (!req) begin
      cnt_d = LOAD;
    end else if (waiting && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: instruction fetch, optional data access, one cpu step.
// Optional bus-timeout watchdog (bus_err, HALT) enabled by defining MEM_ARB_TIMEOUT_EN.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] inst,
  output logic [31:0] load_data,
  output logic        cpu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        rd_q, rd_d;
  logic        req_int;

  assign req_int = (state_q == ST_FETCH) || (state_q == ST_DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_hit;
  logic bus_err_q, bus_err_d;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .req     (req_int),
    .ack     (mem_ack),
    .expired (timeout_hit)
  );

  assign bus_err = bus_err_q;
`else
  // The parameter only shapes the watchdog; referenced here so both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end

  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    load_data_d = load_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rd_d        = rd_q;
`ifdef MEM_ARB_TIMEOUT_EN
    bus_err_d   = bus_err_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          inst_d  = mem_rdata;
          state_d = ST_DECODE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
`endif
      end
      ST_DECODE: begin
        // Data-phase bus fields are captured here so they stay frozen until the ack.
        if (load || store) begin
          addr_d  = address;
          we_d    = store;
          wdata_d = store ? store_data : 32'h0;
          rd_d    = load & ~store;
          state_d = ST_DATA;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          if (rd_q) begin
            load_data_d = mem_rdata;
          end
          state_d = ST_COMMIT;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
`endif
      end
      ST_COMMIT: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      inst_q      <= NOP_INST;
      load_data_q <= 32'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      load_data_q <= load_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  // Bus and step outputs are gated by reset so an in-flight transfer is dropped at once.
  assign mem_req   = ~reset & req_int;
  assign mem_we    = ~reset & (state_q == ST_DATA) & we_q;
  assign mem_addr  = reset                  ? 32'h0 :
                     (state_q == ST_FETCH)  ? pc    :
                     (state_q == ST_DATA)   ? addr_q : 32'h0;
  assign mem_wdata = mem_we ? wdata_q : 32'h0;
  assign cpu_en    = ~reset & ((state_q == ST_COMMIT) |
                               ((state_q == ST_DECODE) & ~load & ~store));
  assign inst      = inst_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays cpu and memory and
// predicts each cycle from a per-instruction transaction model.
module tb_mem_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] inst, load_data, mem_addr, mem_wdata;
  logic        cpu_en, mem_req, mem_we, bus_err;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] pc_m = 32'h0;
  logic [31:0] exp_inst = NOP;
  logic [31:0] exp_ld = 32'h0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .pc(pc), .load(load), .store(store),
    .address(address), .store_data(store_data), .inst(inst), .load_data(load_data),
    .cpu_en(cpu_en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

  // One instruction: fetch (fdel wait cycles), decode, optional data phase (ddel waits), commit.
  task automatic run_instr(input logic [31:0] rdata, input bit ld, input bit st,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] ldval, input int fdel, input int ddel,
                           input bit spur);
    bit mem_op;
    mem_op = ld | st;
    for (int i = 0; i <= fdel; i++) begin
      @(negedge clock);
      pc = pc_m; load = 1'($urandom); store = 1'($urandom);
      address = $urandom; store_data = $urandom;
      mem_ack = (i == fdel); mem_rdata = (i == fdel) ? rdata : $urandom;
      #1;
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_en, bus_err} !== {1'b1, 1'b0, pc_m, 32'h0, 1'b0, 1'b0})
        $display("FAIL fetch_bus got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata, cpu_en, bus_err},
                 {1'b1, 1'b0, pc_m, 32'h0, 1'b0, 1'b0});
      else n_pass++;
      n_checks++;
      if ({inst, load_data} !== {exp_inst, exp_ld})
        $display("FAIL fetch_regs got %h exp %h", {inst, load_data}, {exp_inst, exp_ld});
      else n_pass++;
    end
    exp_inst = rdata;

    @(negedge clock);
    load = ld; store = st; address = addr; store_data = sdata;
    mem_ack = spur; mem_rdata = $urandom;
    #1;
    n_checks++;
    if ({mem_req, cpu_en, bus_err} !== {1'b0, ~mem_op, 1'b0})
      $display("FAIL decode_ctl got %b exp %b", {mem_req, cpu_en, bus_err}, {1'b0, ~mem_op, 1'b0});
    else n_pass++;
    n_checks++;
    if ({inst, load_data} !== {exp_inst, exp_ld})
      $display("FAIL decode_regs got %h exp %h", {inst, load_data}, {exp_inst, exp_ld});
    else n_pass++;
    n_checks++;
    if (!mem_we && (mem_wdata !== 32'h0))
      $display("FAIL decode_wdata got %h exp 00000000", mem_wdata);
    else n_pass++;
    if (!mem_op) begin
      pc_m = pc_m + 32'd4;
      return;
    end

    for (int j = 0; j <= ddel; j++) begin
      @(negedge clock);
      mem_ack = (j == ddel); mem_rdata = (j == ddel) ? ldval : $urandom;
      #1;
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_en, bus_err} !==
          {1'b1, st, addr, (st ? sdata : 32'h0), 1'b0, 1'b0})
        $display("FAIL data_bus got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata, cpu_en, bus_err},
                 {1'b1, st, addr, (st ? sdata : 32'h0), 1'b0, 1'b0});
      else n_pass++;
      n_checks++;
      if ({inst, load_data} !== {exp_inst, exp_ld})
        $display("FAIL data_regs got %h exp %h", {inst, load_data}, {exp_inst, exp_ld});
      else n_pass++;
    end
    if (ld && !st) exp_ld = ldval;

    @(negedge clock);
    load = 1'($urandom); store = 1'($urandom); address = $urandom;
    mem_ack = spur; mem_rdata = $urandom;
    #1;
    n_checks++;
    if ({mem_req, cpu_en, bus_err} !== 3'b010)
      $display("FAIL commit_ctl got %b exp 010", {mem_req, cpu_en, bus_err});
    else n_pass++;
    n_checks++;
    if ({inst, load_data} !== {exp_inst, exp_ld})
      $display("FAIL commit_regs got %h exp %h", {inst, load_data}, {exp_inst, exp_ld});
    else n_pass++;
    pc_m = $urandom & 32'hFFFF_FFFC;
  endtask

  // Holds reset across cycles with a stray ack, then releases it mid-cycle.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      mem_ack = 1'b1; mem_rdata = $urandom; load = 1'b1; store = 1'b1;
      #1;
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_en, bus_err, inst, load_data} !==
          {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, NOP, 32'h0})
        $display("FAIL %s_vals got %h exp %h", tag,
                 {mem_req, mem_we, mem_addr, mem_wdata, cpu_en, bus_err, inst, load_data},
                 {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, NOP, 32'h0});
      else n_pass++;
    end
    exp_inst = NOP; exp_ld = 32'h0;
    reset = 1'b0; mem_ack = 1'b0; pc = pc_m;
    #1;
    n_checks++;
    if ({mem_req, mem_addr, cpu_en, bus_err} !== {1'b1, pc_m, 1'b0, 1'b0})
      $display("FAIL %s_first_fetch got %h exp %h", tag, {mem_req, mem_addr, cpu_en, bus_err},
               {1'b1, pc_m, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_reset();
    pc_m = 32'h0;
    apply_reset("reset");
  endtask

  task automatic test_nonmem();
    run_instr(32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_load();
    run_instr($urandom, 1'b1, 1'b0, 32'h100, $urandom, 32'hDEAD_BEEF, 0, 0, 1'b0);
  endtask

  task automatic test_store_delayed();
    run_instr($urandom, 1'b0, 1'b1, 32'h200, 32'h1234_5678, $urandom, 0, 3, 1'b0);
  endtask

  task automatic test_load_and_store();
    run_instr($urandom, 1'b1, 1'b1, 32'h300, 32'hA5A5_5A5A, 32'h7777_0000, 1, 1, 1'b0);
  endtask

  task automatic test_spurious_ack();
    run_instr($urandom, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 0, 1'b1);
    run_instr($urandom, 1'b1, 1'b0, 32'h440, 32'h0, 32'hCAFE_F00D, 0, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic test_reset_in_data();
    @(negedge clock);
    pc = pc_m; mem_ack = 1'b1; mem_rdata = 32'h0000_0003;
    @(negedge clock);
    load = 1'b1; store = 1'b0; address = 32'h800; mem_ack = 1'b0;
    @(negedge clock);
    mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h800})
      $display("FAIL abort_pre got %h exp %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h800});
    else n_pass++;
    apply_reset("abort");
    run_instr($urandom, 1'b1, 1'b0, $urandom, $urandom, $urandom, 0, 1, 1'b0);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      pc = pc_m; mem_ack = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, mem_addr, bus_err} !== {1'b1, pc_m, 1'b0})
        $display("FAIL timeout_wait got %h exp %h", {mem_req, mem_addr, bus_err}, {1'b1, pc_m, 1'b0});
      else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      mem_ack = 1'($urandom); mem_rdata = $urandom; load = 1'b0; store = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, cpu_en, bus_err} !== 3'b001)
        $display("FAIL timeout_halt got %b exp 001", {mem_req, cpu_en, bus_err});
      else n_pass++;
    end
    apply_reset("timeout_reset");
    run_instr($urandom, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2, 0, 1'b0);
  endtask
`else
  task automatic test_long_wait();
    run_instr($urandom, 1'b1, 1'b0, 32'h900, 32'h0, 32'h1357_9BDF, 12, 9, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store_delayed();
    test_load_and_store();
    test_spurious_ack();
    test_random();
    test_reset_in_data();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
